// File: rtl/tm_pkg.sv
// Shared constants, FSM state encoding and weight type for the Tsetlin-machine
// clause evaluation and feedback blocks.
package tm_pkg;

    localparam int CLAUSE_NUM   = 128;
    localparam int LITERAL_NUM  = 272;
    localparam int WEIGHT_WIDTH = 8;
    localparam int STATE_WIDTH  = 3;

    // One bit above weight width plus clause-count growth, so the full sum never wraps.
    function automatic int sum_width(input int weight_width, input int clause_num);
        return weight_width + $clog2(clause_num) + 1;
    endfunction

    localparam int SUM_WIDTH = sum_width(WEIGHT_WIDTH, CLAUSE_NUM);

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE,
        ST_FEEDBACK,
        ST_SETTLE
    } state_e;

    typedef logic signed [WEIGHT_WIDTH-1:0] weight_t;

endpackage

// File: rtl/tm_clause_eval_if.sv
// Sample input, include-memory read, result output and feedback signals of the
// clause evaluator; slave is the evaluator side, master the surrounding system.
interface tm_clause_eval_if #(
    parameter int CLAUSE_NUM   = tm_pkg::CLAUSE_NUM,
    parameter int LITERAL_NUM  = tm_pkg::LITERAL_NUM,
    parameter int WEIGHT_WIDTH = tm_pkg::WEIGHT_WIDTH,
    parameter int SUM_WIDTH    = tm_pkg::sum_width(WEIGHT_WIDTH, CLAUSE_NUM),
    parameter int ADDR_WIDTH   = $clog2(CLAUSE_NUM)
);
    logic                               in_valid;
    logic                               in_ready;
    logic [LITERAL_NUM-1:0]             in_literals;
    logic                               in_label;
    logic                               in_train;
    logic                               inc_rd_en;
    logic [ADDR_WIDTH-1:0]              inc_rd_addr;
    logic [LITERAL_NUM-1:0]             inc_rd_data;
    logic [CLAUSE_NUM*WEIGHT_WIDTH-1:0] weight_in;
    logic                               out_valid;
    logic                               out_ready;
    logic [CLAUSE_NUM-1:0]              conjunction_result;
    logic [SUM_WIDTH-1:0]               class_sum;
    logic                               prediction;
    logic                               fb_en;
    logic                               is_positive_sample;

    modport master (
        output in_valid, in_literals, in_label, in_train, inc_rd_data, weight_in, out_ready,
        input  in_ready, inc_rd_en, inc_rd_addr, out_valid, conjunction_result, class_sum,
               prediction, fb_en, is_positive_sample
    );

    modport slave (
        input  in_valid, in_literals, in_label, in_train, inc_rd_data, weight_in, out_ready,
        output in_ready, inc_rd_en, inc_rd_addr, out_valid, conjunction_result, class_sum,
               prediction, fb_en, is_positive_sample
    );

endinterface

// File: rtl/tm_clause_match.sv
// Single-clause conjunction: every included literal must be 1; a clause with no
// includes passes only while training.
module tm_clause_match #(
    parameter int LITERAL_NUM = tm_pkg::LITERAL_NUM
) (
    input  logic [LITERAL_NUM-1:0] mask,
    input  logic [LITERAL_NUM-1:0] literals,
    input  logic                   train,
    output logic                   match
);

    always_comb begin
        if (mask == '0) begin
            match = train;
        end else begin
            match = &(~mask | literals);
        end
    end

endmodule

// File: rtl/tm_clause_eval.sv
// Latches a sample, walks the include-mask memory one clause per cycle, builds the
// conjunction vector and weighted class sum, then optionally pulses feedback.
module tm_clause_eval #(
    parameter int CLAUSE_NUM   = tm_pkg::CLAUSE_NUM,
    parameter int LITERAL_NUM  = tm_pkg::LITERAL_NUM,
    parameter int WEIGHT_WIDTH = tm_pkg::WEIGHT_WIDTH,
    parameter int SUM_WIDTH    = tm_pkg::sum_width(WEIGHT_WIDTH, CLAUSE_NUM),
    parameter int ADDR_WIDTH   = $clog2(CLAUSE_NUM)
) (
    input logic             clk,
    input logic             rst,
    tm_clause_eval_if.slave bus
);
    import tm_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CLAUSE_NUM - 1);

    state_e                   state_q, state_d;
    logic                     in_ready_q, in_ready_d;
    logic [LITERAL_NUM-1:0]   literals_q, literals_d;
    logic                     label_q, label_d;
    logic                     train_q, train_d;
    logic                     rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
    logic                     pend_valid_q, pend_valid_d;
    logic [ADDR_WIDTH-1:0]    pend_addr_q, pend_addr_d;
    logic [CLAUSE_NUM-1:0]    conj_q, conj_d;
    logic [SUM_WIDTH-1:0]     acc_q, acc_d;
    logic                     prediction_q, prediction_d;
    logic                     out_valid_q, out_valid_d;
    logic                     fb_en_q, fb_en_d;

    logic                     clause_match;
    logic [WEIGHT_WIDTH-1:0]  weight_k;
    logic [SUM_WIDTH-1:0]     weight_ext;

    tm_clause_match #(
        .LITERAL_NUM (LITERAL_NUM)
    ) u_match (
        .mask     (bus.inc_rd_data),
        .literals (literals_q),
        .train    (train_q),
        .match    (clause_match)
    );

    // pend_addr_q names the clause whose mask is on inc_rd_data this cycle.
    assign weight_k   = bus.weight_in[int'(pend_addr_q) * WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign weight_ext = {{(SUM_WIDTH - WEIGHT_WIDTH){weight_k[WEIGHT_WIDTH-1]}}, weight_k};

    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        literals_d   = literals_q;
        label_d      = label_q;
        train_d      = train_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        pend_valid_d = rd_en_q;
        pend_addr_d  = rd_addr_q;
        conj_d       = conj_q;
        acc_d        = acc_q;
        prediction_d = prediction_q;
        out_valid_d  = out_valid_q;
        fb_en_d      = 1'b0;

        if (pend_valid_q && clause_match) begin
            conj_d[pend_addr_q] = 1'b1;
            acc_d               = acc_q + weight_ext;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d      = ST_READ;
                    in_ready_d   = 1'b0;
                    literals_d   = bus.in_literals;
                    label_d      = bus.in_label;
                    train_d      = bus.in_train;
                    conj_d       = '0;
                    acc_d        = '0;
                    prediction_d = 1'b0;
                    rd_en_d      = 1'b1;
                    rd_addr_d    = '0;
                end
            end
            ST_READ: begin
                if (rd_addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                state_d      = ST_DONE;
                out_valid_d  = 1'b1;
                prediction_d = ~acc_d[SUM_WIDTH-1];
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (train_q) begin
                        state_d = ST_FEEDBACK;
                        fb_en_d = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        in_ready_d = 1'b1;
                    end
                end
            end
            // One quiet cycle lets the downstream feedback update finish before a new accept.
            ST_FEEDBACK: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b1;
            literals_q   <= '0;
            label_q      <= 1'b0;
            train_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            conj_q       <= '0;
            acc_q        <= '0;
            prediction_q <= 1'b0;
            out_valid_q  <= 1'b0;
            fb_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            literals_q   <= literals_d;
            label_q      <= label_d;
            train_q      <= train_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            conj_q       <= conj_d;
            acc_q        <= acc_d;
            prediction_q <= prediction_d;
            out_valid_q  <= out_valid_d;
            fb_en_q      <= fb_en_d;
        end
    end

    assign bus.in_ready           = in_ready_q;
    assign bus.inc_rd_en          = rd_en_q;
    assign bus.inc_rd_addr        = rd_addr_q;
    assign bus.out_valid          = out_valid_q;
    assign bus.conjunction_result = conj_q;
    assign bus.class_sum          = acc_q;
    assign bus.prediction         = prediction_q;
    assign bus.fb_en              = fb_en_q;
    assign bus.is_positive_sample = label_q;

endmodule
